// File: rtl/pq_access_arbiter.sv
// Round-robin arbiter sharing one priority queue among NUM_REQ requesters: accept -> strobe next cycle -> settle wait -> one-cycle response.
// Latency: RESP at accept+2+ENQ_WAIT/OP_WAIT, or accept+1 for rejected requests; ready held low while busy, no response back-pressure.
module pq_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int QUEUE_SIZE = 15,
  parameter int ENQ_ENA    = 1,
  parameter int ENQ_WAIT   = $clog2(QUEUE_SIZE),
  parameter int OP_WAIT    = 2,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_CLK,
  input  logic                          i_RSTn,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [2*NUM_REQ-1:0]          i_req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [ID_W-1:0]               o_rsp_id,
  output logic [DATA_WIDTH-1:0]         o_rsp_data,
  output logic                          o_rsp_err,
  output logic                          o_busy,
  output logic                          o_q_wrt,
  output logic                          o_q_read,
  output logic [DATA_WIDTH-1:0]         o_q_data,
  input  logic                          i_q_full,
  input  logic                          i_q_empty,
  input  logic [DATA_WIDTH-1:0]         i_q_data
);

  localparam int MAX_WAIT = (ENQ_WAIT > OP_WAIT) ? ENQ_WAIT : OP_WAIT;
  localparam int CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                r_state, w_next_state;
  logic [ID_W-1:0]       r_rr_ptr, r_id;
  logic [1:0]            r_op;
  logic [DATA_WIDTH-1:0] r_data, r_old_top;
  logic                  r_err;
  logic [CNT_W-1:0]      r_cnt;

  logic                  w_gnt_vld;
  logic [ID_W-1:0]       w_gnt_idx, w_ptr_next;
  logic [1:0]            w_op_sel;
  logic [DATA_WIDTH-1:0] w_data_sel;
  logic                  w_legal;
  logic [CNT_W-1:0]      w_wait_len;
  int                    w_best, w_dist;

  // Pick the valid requester with the smallest wrapped distance from the pointer.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_best     = NUM_REQ;
    w_dist     = 0;
    w_op_sel   = 2'b00;
    w_data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(r_rr_ptr);
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (i_req_valid[i] && (w_dist < w_best)) begin
        w_best    = w_dist;
        w_gnt_idx = ID_W'(i);
        w_gnt_vld = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_op_sel   = i_req_op[2*i +: 2];
        w_data_sel = i_req_data[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    case (w_op_sel)
      2'b00:   w_legal = (ENQ_ENA != 0) && !i_q_full;
      2'b01:   w_legal = !i_q_empty;
      2'b10:   w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_ptr_next = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);
  assign w_wait_len = (r_op == 2'b00) ? CNT_W'(ENQ_WAIT) : CNT_W'(OP_WAIT);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_id      <= '0;
      r_op      <= 2'b00;
      r_data    <= '0;
      r_old_top <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_op      <= w_op_sel;
            r_data    <= w_data_sel;
            r_id      <= w_gnt_idx;
            r_rr_ptr  <= w_ptr_next;
            r_old_top <= i_q_empty ? '0 : i_q_data;
            r_err     <= !w_legal;
          end
        end
        S_ISSUE: r_cnt <= w_wait_len;
        S_WAIT:  r_cnt <= r_cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_req_ready  = '0;
    o_rsp_valid  = 1'b0;
    o_rsp_id     = '0;
    o_rsp_data   = '0;
    o_rsp_err    = 1'b0;
    o_q_wrt      = 1'b0;
    o_q_read     = 1'b0;
    o_q_data     = '0;
    o_busy       = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        // Ready is held off while reset is asserted so no accept can be seen during reset.
        for (int i = 0; i < NUM_REQ; i++)
          o_req_ready[i] = i_RSTn && w_gnt_vld && (w_gnt_idx == ID_W'(i));
        if (w_gnt_vld) w_next_state = w_legal ? S_ISSUE : S_RESP;
      end
      S_ISSUE: begin
        o_q_wrt      = (r_op == 2'b00) || (r_op == 2'b10);
        o_q_read     = (r_op == 2'b01) || (r_op == 2'b10);
        o_q_data     = o_q_wrt ? r_data : '0;
        w_next_state = (w_wait_len == '0) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= CNT_W'(1)) w_next_state = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid  = 1'b1;
        o_rsp_id     = r_id;
        o_rsp_err    = r_err;
        o_rsp_data   = (!r_err && ((r_op == 2'b01) || (r_op == 2'b10))) ? r_old_top : '0;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pq_access_arbiter.sv
// Directed bench for pq_access_arbiter with a behavioural max-first queue attached to the strobes.
module tb_pq_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [7:0]  req_op;
  logic [63:0] req_data;
  logic [3:0]  o_req_ready;
  logic        o_rsp_valid, o_rsp_err, o_busy, o_q_wrt, o_q_read;
  logic [1:0]  o_rsp_id;
  logic [15:0] o_rsp_data, o_q_data;

  logic [3:0]  ne_valid;
  logic [7:0]  ne_op;
  logic [63:0] ne_data;
  logic [3:0]  ne_ready;
  logic        ne_rsp_valid, ne_rsp_err, ne_busy, ne_wrt, ne_read;
  logic [1:0]  ne_rsp_id;
  logic [15:0] ne_rsp_data, ne_q_data;

  logic [15:0] qm [0:15];
  int          qcnt = 0;
  int          q_maxi;
  logic [15:0] q_max, q_top;
  logic        q_clr, q_full, q_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pq_access_arbiter u_dut (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_req_valid(req_valid), .i_req_op(req_op), .i_req_data(req_data),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err), .o_busy(o_busy),
    .o_q_wrt(o_q_wrt), .o_q_read(o_q_read), .o_q_data(o_q_data),
    .i_q_full(q_full), .i_q_empty(q_empty), .i_q_data(q_top)
  );

  pq_access_arbiter #(.ENQ_ENA(0)) u_dut_ne (
    .i_CLK(clk), .i_RSTn(rst_n),
    .i_req_valid(ne_valid), .i_req_op(ne_op), .i_req_data(ne_data),
    .o_req_ready(ne_ready), .o_rsp_valid(ne_rsp_valid), .o_rsp_id(ne_rsp_id),
    .o_rsp_data(ne_rsp_data), .o_rsp_err(ne_rsp_err), .o_busy(ne_busy),
    .o_q_wrt(ne_wrt), .o_q_read(ne_read), .o_q_data(ne_q_data),
    .i_q_full(1'b0), .i_q_empty(1'b1), .i_q_data(16'd0)
  );

  // Behavioural queue: unordered storage, top is the maximum stored key.
  always_comb begin
    q_max  = '0;
    q_maxi = 0;
    for (int i = 0; i < 16; i++) begin
      if ((i < qcnt) && ((i == 0) || (qm[i] > q_max))) begin
        q_max  = qm[i];
        q_maxi = i;
      end
    end
  end
  assign q_top   = (qcnt == 0) ? 16'd0 : q_max;
  assign q_full  = (qcnt == 15);
  assign q_empty = (qcnt == 0);

  always @(posedge clk) begin
    if (q_clr) qcnt <= 0;
    else if (o_q_wrt && o_q_read) begin
      if (qcnt == 0) begin qm[0] <= o_q_data; qcnt <= 1; end
      else qm[q_maxi] <= o_q_data;
    end else if (o_q_wrt && (qcnt < 15)) begin
      qm[qcnt] <= o_q_data;
      qcnt     <= qcnt + 1;
    end else if (o_q_read && (qcnt > 0)) begin
      qm[q_maxi] <= qm[qcnt-1];
      qcnt       <= qcnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queue();
    q_clr = 1'b1;
    tick();
    q_clr = 1'b0;
  endtask

  // Presents one request at posedge+1, expects acceptance this cycle and the response lat cycles later.
  task automatic run_op(input string tag, input int id, input logic [1:0] op, input logic [15:0] d,
                        input int lat, input int exp_w, input int exp_r,
                        input logic [15:0] exp_rd, input logic exp_err);
    int nw, nr, early;
    logic s_w, s_r;
    logic [15:0] s_qd;
    logic [3:0] one;
    one = 4'b0001 << id;
    req_valid[id]       = 1'b1;
    req_op[2*id +: 2]   = op;
    req_data[16*id +: 16] = d;
    #1;
    check({tag, ".ready"}, o_req_ready, one);
    tick();
    req_valid[id] = 1'b0;
    s_w = o_q_wrt; s_r = o_q_read; s_qd = o_q_data;
    nw = 0; nr = 0; early = 0;
    for (int c = 1; c < lat; c++) begin
      nw += o_q_wrt; nr += o_q_read; early += o_rsp_valid;
      tick();
    end
    nw += o_q_wrt; nr += o_q_read;
    check({tag, ".rsp_valid"}, o_rsp_valid, 1);
    check({tag, ".rsp_id"}, o_rsp_id, id);
    check({tag, ".rsp_data"}, o_rsp_data, exp_rd);
    check({tag, ".rsp_err"}, o_rsp_err, exp_err);
    check({tag, ".wrt_t1"}, s_w, exp_w);
    check({tag, ".read_t1"}, s_r, exp_r);
    if (exp_w != 0) check({tag, ".qdata_t1"}, s_qd, d);
    check({tag, ".wrt_count"}, nw, exp_w);
    check({tag, ".read_count"}, nr, exp_r);
    check({tag, ".early_rsp"}, early, 0);
    tick();
    check({tag, ".rsp_after"}, o_rsp_valid, 0);
    check({tag, ".idle_after"}, o_busy, 0);
  endtask

  initial begin
    int gnt [0:7];
    int st [0:7];
    logic [15:0] sd [0:7];
    int ng, ns, multi, cyc, early;

    rst_n = 1'b0; q_clr = 1'b1;
    req_valid = 4'b1111; req_op = '0; req_data = '0;
    ne_valid = '0; ne_op = '0; ne_data = '0;
    #2;
    check("reset.ready", o_req_ready, 0);
    check("reset.busy", o_busy, 0);
    check("reset.rsp", {o_rsp_valid, o_rsp_err, o_rsp_id, o_rsp_data}, 0);
    check("reset.q", {o_q_wrt, o_q_read, o_q_data}, 0);
    req_valid = '0;
    tick(); tick();
    rst_n = 1'b1; q_clr = 1'b0;
    tick();

    run_op("enq100", 0, 2'b00, 16'd100, 6, 1, 0, 16'd0, 1'b0);
    check("enq100.top", q_top, 100);

    clear_queue();
    run_op("enq300", 1, 2'b00, 16'd300, 6, 1, 0, 16'd0, 1'b0);
    run_op("enq120", 2, 2'b00, 16'd120, 6, 1, 0, 16'd0, 1'b0);
    run_op("deq", 1, 2'b01, 16'd0, 4, 0, 1, 16'd300, 1'b0);
    check("deq.top", q_top, 120);

    run_op("enq900", 2, 2'b00, 16'd900, 6, 1, 0, 16'd0, 1'b0);
    run_op("repl50", 0, 2'b10, 16'd50, 4, 1, 1, 16'd900, 1'b0);
    check("repl50.top", q_top, 120);
    check("repl50.count", qcnt, 2);

    clear_queue();
    run_op("deq_empty", 2, 2'b01, 16'd0, 1, 0, 0, 16'd0, 1'b1);
    run_op("repl_empty", 1, 2'b10, 16'd7, 4, 1, 1, 16'd0, 1'b0);
    check("repl_empty.top", q_top, 7);
    run_op("op11", 0, 2'b11, 16'd1, 1, 0, 0, 16'd0, 1'b1);

    clear_queue();
    for (int i = 0; i < 15; i++) run_op("fill", 3, 2'b00, 16'(i + 20), 6, 1, 0, 16'd0, 1'b0);
    check("fill.full", q_full, 1);
    run_op("enq_full", 3, 2'b00, 16'd5, 1, 0, 0, 16'd0, 1'b1);
    check("enq_full.count", qcnt, 15);

    // All four requesters contend from reset.
    rst_n = 1'b0; q_clr = 1'b1;
    tick(); tick();
    rst_n = 1'b1; q_clr = 1'b0;
    req_op = 8'h00;
    req_data = {16'd40, 16'd30, 16'd20, 16'd10};
    req_valid = 4'b1111;
    ng = 0; ns = 0; multi = 0; cyc = 0;
    while ((ns < 5) && (cyc < 80)) begin
      #1;
      if ($countones(o_req_ready) > 1) multi++;
      if ((o_req_ready != 4'b0) && (ng < 8)) begin
        for (int k = 0; k < 4; k++) if (o_req_ready[k]) gnt[ng] = k;
        ng++;
      end
      if (o_q_wrt && (ns < 8)) begin st[ns] = cyc; sd[ns] = o_q_data; ns++; end
      cyc++;
      tick();
      if (ng >= 5) req_valid = 4'b0000;
    end
    req_valid = 4'b0000;
    check("rr.grants", ng, 5);
    check("rr.strobes", ns, 5);
    check("rr.multi_ready", multi, 0);
    check("rr.order", {gnt[0][3:0], gnt[1][3:0], gnt[2][3:0], gnt[3][3:0], gnt[4][3:0]}, 20'h01230);
    for (int k = 1; k < 5; k++) check("rr.spacing", st[k] - st[k-1], 7);
    check("rr.data", {sd[0], sd[1]}, {16'd10, 16'd20});
    check("rr.data2", {sd[2], sd[3]}, {16'd30, 16'd40});
    check("rr.data3", sd[4], 10);
    for (int i = 0; (i < 20) && o_busy; i++) tick();
    check("rr.idle", o_busy, 0);
    check("rr.top", q_top, 40);

    // Reset in the middle of an enqueue settle window.
    req_valid[0] = 1'b1; req_op[1:0] = 2'b00; req_data[15:0] = 16'd77;
    tick();
    req_valid[0] = 1'b0;
    tick(); tick();
    check("abort.in_wait", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort.busy", o_busy, 0);
    check("abort.outs", {o_q_wrt, o_q_read, o_q_data, o_rsp_valid, o_rsp_err, o_rsp_id, o_rsp_data, o_req_ready}, 0);
    early = 0;
    for (int i = 0; i < 3; i++) begin tick(); early += o_rsp_valid; end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); early += o_rsp_valid; end
    check("abort.no_rsp", early, 0);
    req_valid = 4'b0011;
    req_op = 8'h00;
    #1;
    check("abort.ptr_reset", o_req_ready, 4'b0001);
    req_valid = 4'b0000;
    tick();
    for (int i = 0; (i < 20) && o_busy; i++) tick();

    // Build without enqueue support: enqueue is rejected.
    ne_valid[2] = 1'b1; ne_op[5:4] = 2'b00; ne_data[47:32] = 16'd9;
    #1;
    check("noenq.ready", ne_ready, 4'b0100);
    tick();
    ne_valid[2] = 1'b0;
    check("noenq.rsp", {ne_rsp_valid, ne_rsp_err, ne_rsp_id}, {1'b1, 1'b1, 2'd2});
    check("noenq.data", ne_rsp_data, 0);
    check("noenq.strobes", {ne_wrt, ne_read, ne_q_data}, 0);
    tick();
    check("noenq.idle", {ne_busy, ne_rsp_valid}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pq_access_arbiter.md
Name: pq_access_arbiter

Overview:
- Shares one register-tree priority queue (max-first) among NUM_REQ requesters.
- Each requester issues enqueue, dequeue or replace through a valid/ready handshake. The block arbitrates round-robin, drives the queue's one-cycle write/read strobes, and waits out the queue's settle time before the next operation.
- Returns a single-cycle response carrying the removed top value and an error flag.
- Sits between client logic and the queue instance. The queue's full/empty/top outputs feed back into this block.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 16, key width; must match the queue.
- QUEUE_SIZE, 15, queue capacity; used only to derive ENQ_WAIT.
- ENQ_ENA, 1, mirrors queue build option; 0 = enqueue requests rejected with error.
- ENQ_WAIT, $clog2(QUEUE_SIZE), settle cycles after an enqueue strobe.
- OP_WAIT, 2, settle cycles after a dequeue/replace strobe.

Ports:
- i_CLK  in  1  clock.
- i_RSTn  in  1  asynchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- i_req_op  in  2*NUM_REQ  per-requester op: 00 enq, 01 deq, 10 replace, 11 illegal.
- i_req_data  in  DATA_WIDTH*NUM_REQ  per-requester key.
- o_req_ready  out  NUM_REQ  one-hot accept.
- o_rsp_valid  out  1  response pulse.
- o_rsp_id  out  ID_W = max(1,$clog2(NUM_REQ))  index of the responding requester.
- o_rsp_data  out  DATA_WIDTH  removed top value (deq/replace), else 0.
- o_rsp_err  out  1  request rejected.
- o_busy  out  1  high whenever state != IDLE.
- o_q_wrt  out  1  queue write strobe.
- o_q_read  out  1  queue read strobe.
- o_q_data  out  DATA_WIDTH  queue write data.
- i_q_full  in  1  queue full.
- i_q_empty  in  1  queue empty.
- i_q_data  in  DATA_WIDTH  queue top.

Behaviour:
- Reset (async, i_RSTn=0):
  - State IDLE; rr_ptr=0.
  - All outputs 0: o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err, o_busy, o_q_wrt, o_q_read, o_q_data.
  - Reset mid-operation aborts immediately: no strobe or response completes.
- Requester rules:
  - Holds valid/op/data stable until ready is asserted.
  - Handshake = valid & ready in the same cycle.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any valid, grant the first valid index searching from rr_ptr upward with wrap. o_req_ready[g]=1 combinationally in that cycle.
  - On accept: register op, data, id=g; rr_ptr <= (g+1) mod NUM_REQ.
  - Snapshot old_top = i_q_empty ? 0 : i_q_data.
  - Evaluate legality using i_q_full/i_q_empty in that same cycle:
    - enq legal iff ENQ_ENA && !i_q_full.
    - deq legal iff !i_q_empty.
    - replace always legal.
    - op 11 always illegal.
  - Legal request -> ISSUE. Illegal -> RESP with err=1.
- ISSUE (1 cycle): drive strobes for exactly this cycle.
  - enq: o_q_wrt=1, o_q_data=data.
  - deq: o_q_read=1.
  - replace: both strobes=1, o_q_data=data.
  - Load counter with ENQ_WAIT (enq) or OP_WAIT (deq/replace); go to WAIT.
- WAIT: strobes low; decrement counter; stays exactly ENQ_WAIT or OP_WAIT cycles, then RESP.
- RESP (1 cycle):
  - o_rsp_valid=1 and o_rsp_id=id.
  - o_rsp_data = old_top for deq/replace; 0 for enq or any error.
  - o_rsp_err = error flag.
  - Next state IDLE.
- o_rsp_* are 0 outside RESP; there is no response back-pressure.
- Timing, accept at cycle T:
  - Strobe at T+1.
  - RESP at T+2+WAIT: enq T+6 (QUEUE_SIZE=15); deq/replace T+4.
  - Illegal request: RESP at T+1, no strobe.
  - Next accept no earlier than the cycle after RESP.
- Replace on empty queue: legal, err=0, rsp_data=0.
- Requesters not granted are never readied; their data is ignored.

Test Plan:
- Reset, req0 enq 100 into empty queue, accepted at T -> o_q_wrt=1 with o_q_data=100 only at T+1; rsp at T+6 with id=0, err=0, data=0; queue top then reads 100.
- Queue holding {300,120}, req1 deq at T -> o_q_read pulse at T+1; rsp at T+4 with id=1, data=300; queue top becomes 120.
- All four requesters hold valid enq (values 10,20,30,40) from reset -> grants in order 0,1,2,3, then 0 again; strobes spaced exactly 7 cycles apart; never two ready bits in one cycle.
- Empty queue, req2 deq -> rsp at T+1 with err=1, data=0, no strobe.
- Full queue (15 entries), req3 enq 5 -> same error response.
- With ENQ_ENA=0, any enq -> same error response.
- Top=900, req0 replace 50 -> o_q_wrt=o_q_read=1 in the same single cycle; rsp data=900, err=0; new top is the max of the remaining entries and 50.
- i_RSTn low during WAIT of an enq -> all outputs 0 at once, no rsp pulse. After release with req1 and req0 valid, req0 is granted first (rr_ptr=0).
